// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: samples rx mid-bit on s_tick strobes and
// delivers each word with a one-cycle done pulse plus parity/framing status.
module uart_rx_oversampled #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);
    localparam int   SW  = (SB_TICK > 16) ? 5 : 4;
    localparam int   NW  = $clog2(DBIT);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            perr_q, perr_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            perr_o_q, perr_o_d;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            s_q      <= '0;
            n_q      <= '0;
            b_q      <= '0;
            p_q      <= 1'b0;
            perr_q   <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_o_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            p_q      <= p_d;
            perr_q   <= perr_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            perr_o_q <= perr_o_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        p_d      = p_q;
        perr_d   = perr_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        ferr_d   = ferr_q;
        perr_o_d = perr_o_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    s_d     = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        // Line high again at mid start bit: treat as a glitch.
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            s_d     = '0;
                            n_d     = '0;
                            p_d     = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        p_d = p_q ^ rx_s_q;
                        if (n_q == NW'(DBIT-1))
                            state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                        else
                            n_d = n_q + 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        perr_d  = p_q ^ rx_s_q ^ ODD;
                        state_d = S_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK-1)) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        dout_d   = b_q;
                        ferr_d   = ~rx_s_q;
                        perr_o_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_o_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != S_IDLE);
endmodule
